// File: rtl/divider_ramp_ctrl_pkg.sv
// Shared definitions for the divider ramp controller.
//   ctrl_state_e  : controller state encoding (idle / ramping / stopping)
//   clamp_factor  : saturate a value into [lo, hi]; operands are carried at 64 bits
//                   so callers of any WIDTH up to 64 can zero-extend into it.
package divider_ramp_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRamp     = 2'd1,
        StStopping = 2'd2
    } ctrl_state_e;

    function automatic logic [63:0] clamp_factor(input logic [63:0] value,
                                                 input logic [63:0] lo,
                                                 input logic [63:0] hi);
        logic [63:0] result;
        result = value;
        if (value < lo) begin
            result = lo;
        end else if (value > hi) begin
            result = hi;
        end
        return result;
    endfunction

endpackage

// File: rtl/divider_ramp_ctrl_ramp_tick_gen.sv
// Update-rate tick generator for the divider ramp controller.
//   clk_i  : system clock
//   reset  : synchronous, active-high reset
//   clear  : restart the count from zero
//   enable : count while high; counter is held at zero while low
//   tick   : one-cycle pulse every RAMP_TICKS enabled cycles
module ramp_tick_gen #(
    parameter int unsigned RAMP_TICKS = 1000
) (
    input  logic clk_i,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(RAMP_TICKS - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = enable && !clear && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (cnt_q == LastCnt) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/divider_ramp_ctrl.sv
// Ramp controller for a runtime-factor clock divider driving a motor step clock.
// Slews the divide factor between a parked (slowest) value and a requested target at a
// bounded rate, and holds the divider in reset only once the factor is parked again.
//   clk_i         : system clock
//   reset         : synchronous, active-high reset
//   run           : level, high enables the motor
//   target_factor : requested divide factor
//   target_valid  : one-cycle strobe capturing target_factor (clamped)
//   factor_o      : factor to the divider
//   div_reset     : divider reset, high while parked
//   at_target     : running and factor_o equals the captured target
//   busy          : controller not idle
module divider_ramp_ctrl
    import divider_ramp_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RAMP_TICKS = 1000,
    parameter int unsigned STEP       = 16,
    parameter int unsigned MIN_FACTOR = 2,
    parameter int unsigned MAX_FACTOR = 65536
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] target_factor,
    input  logic             target_valid,
    output logic [WIDTH-1:0] factor_o,
    output logic             div_reset,
    output logic             at_target,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MaxFactor = WIDTH'(MAX_FACTOR);
    localparam logic [WIDTH:0]   StepX     = (WIDTH + 1)'(STEP);

    ctrl_state_e      state_q, state_d;
    logic [WIDTH-1:0] factor_q, factor_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             at_target_q, at_target_d;
    logic             busy_q, busy_d;
    logic             div_reset_q, div_reset_d;

    logic             tick;
    logic             leave_idle;
    logic [WIDTH-1:0] goal;
    logic [WIDTH:0]   factor_x, goal_x, stepped_x;

    ramp_tick_gen #(
        .RAMP_TICKS (RAMP_TICKS)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .reset  (reset),
        .clear  (leave_idle),
        .enable (state_q != StIdle),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StRamp;
            end
            StRamp: begin
                if (!run) state_d = StStopping;
            end
            StStopping: begin
                if (run) begin
                    state_d = StRamp;
                end else if (factor_q == MaxFactor) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign leave_idle = (state_q == StIdle) && (state_d != StIdle);

    // Goal follows the current state; a target captured this cycle is not yet visible here.
    assign goal = (state_q == StRamp) ? target_q : MaxFactor;

    // One extra bit so the distance compare and the upward add can never wrap.
    always_comb begin
        factor_x  = {1'b0, factor_q};
        goal_x    = {1'b0, goal};
        stepped_x = factor_x;
        if (factor_x > goal_x) begin
            stepped_x = ((factor_x - goal_x) > StepX) ? (factor_x - StepX) : goal_x;
        end else if (factor_x < goal_x) begin
            stepped_x = ((goal_x - factor_x) > StepX) ? (factor_x + StepX) : goal_x;
        end
    end

    always_comb begin
        factor_d = factor_q;
        if (state_q == StIdle) begin
            factor_d = MaxFactor;
        end else if (tick) begin
            factor_d = stepped_x[WIDTH-1:0];
        end
    end

    always_comb begin
        target_d = target_q;
        if (target_valid) begin
            target_d = WIDTH'(clamp_factor(64'(target_factor), 64'(MIN_FACTOR),
                                           64'(MAX_FACTOR)));
        end
    end

    assign at_target_d = (state_d == StRamp) && (factor_d == target_d);
    assign busy_d      = (state_d != StIdle);
    assign div_reset_d = (state_d == StIdle);

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q     <= StIdle;
            factor_q    <= MaxFactor;
            target_q    <= MaxFactor;
            at_target_q <= 1'b0;
            busy_q      <= 1'b0;
            div_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            factor_q    <= factor_d;
            target_q    <= target_d;
            at_target_q <= at_target_d;
            busy_q      <= busy_d;
            div_reset_q <= div_reset_d;
        end
    end

    assign factor_o  = factor_q;
    assign at_target = at_target_q;
    assign busy      = busy_q;
    assign div_reset = div_reset_q;

endmodule
